// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: MIPS IF stage owning the PC and IF/ID register; define FETCH_PERF_CNT_EN
// to add saturating stall_cnt/flush_cnt outputs.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [27:0] jump_offset28,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  logic [31:0] pc_q, pc_d, if_id_pc4_q, if_id_pc4_d, if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d, redirect;
  logic [31:0] pc4, target;
  always_comb begin
    pc4           = pc_q + 32'd4;
    redirect      = branch_taken | jump;
    // branch wins over jump when both are (illegally) asserted
    target        = branch_taken ? branch_target : {if_id_pc4_q[31:28], jump_offset28};
    pc_d          = stall ? pc_q : redirect ? target : pc4;
    if_id_pc4_d   = stall ? if_id_pc4_q : redirect ? 32'd0 : pc4;
    if_id_instr_d = stall ? if_id_instr_q : redirect ? NOP_INSTR : instr_in;
    if_id_valid_d = stall ? if_id_valid_q : !redirect;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_pc4_q   <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end
  assign pc          = pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (!stall && redirect && !(&flush_cnt_q)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule
